// File: rtl/vx_commit_arb.sv
// vx_commit_arb: round-robin merge of per-unit commit streams with multi-packet locking and a retire counter.
// Define VX_COMMIT_ARB_FPU_EN to add the FPU stream as input 3.
module vx_commit_arb #(
    parameter int DATAW = 128,
`ifdef VX_COMMIT_ARB_FPU_EN
    localparam int NUM_INPUTS = 4,
`else
    localparam int NUM_INPUTS = 3,
`endif
    localparam int SRCW = $clog2(NUM_INPUTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS-1:0]       in_valid,
    input  logic [NUM_INPUTS*DATAW-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]       in_sop,
    input  logic [NUM_INPUTS-1:0]       in_eop,
    output logic [NUM_INPUTS-1:0]       in_ready,
    output logic                        out_valid,
    output logic [DATAW-1:0]            out_data,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic [SRCW-1:0]             out_src,
    input  logic                        out_ready,
    output logic [31:0]                 retired_count
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;
    localparam logic [SRCW-1:0] LAST = SRCW'(NUM_INPUTS - 1);

    logic [0:0] state;
    logic [SRCW-1:0] ptr, lock_src, gnt_idx;
    logic [NUM_INPUTS-1:0] grant;
    logic stall, accept, sel_sop, sel_eop;
    int j;

    // While locked the owner keeps its grant even when it bubbles, so no other unit can interleave.
    always_comb begin
        grant = '0;
        gnt_idx = lock_src;
        j = 0;
        if (state == LOCKED) begin
            grant[lock_src] = 1'b1;
        end else begin
            for (int k = 0; k < NUM_INPUTS; k++) begin
                j = int'(ptr) + k;
                if (j >= NUM_INPUTS) j = j - NUM_INPUTS;
                if (grant == '0 && in_valid[j]) begin
                    grant[j] = 1'b1;
                    gnt_idx = SRCW'(j);
                end
            end
        end
    end

    assign stall = out_valid && !out_ready;
    assign in_ready = stall ? '0 : grant;
    assign accept = |(in_valid & in_ready);
    assign sel_sop = in_sop[gnt_idx];
    assign sel_eop = in_eop[gnt_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            lock_src <= '0;
            ptr <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_sop <= 1'b0;
            out_eop <= 1'b0;
            out_src <= '0;
            retired_count <= '0;
        end else begin
            if (out_valid && out_ready && out_eop) retired_count <= retired_count + 32'd1;
            if (accept) begin
                out_valid <= 1'b1;
                out_data <= in_data[gnt_idx*DATAW +: DATAW];
                out_sop <= sel_sop;
                out_eop <= sel_eop;
                out_src <= gnt_idx;
                if (sel_eop) ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
                if (state == LOCKED && sel_eop) begin
                    state <= IDLE;
                end else if (state == IDLE && sel_sop && !sel_eop) begin
                    state <= LOCKED;
                    lock_src <= gnt_idx;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Only the lock owner can be accepted while locked, so a sop there means an unterminated instruction.
    sop_in_packet: assert property (@(posedge clk) disable iff (reset) !(accept && state == LOCKED && sel_sop))
        else $error("vx_commit_arb: unit %0d sent sop before eop", gnt_idx);
endmodule
